multi_drive_sector_index_gen: RTL and testbench

Per-drive rotational timing generator for the multi-drive emulator build. There are NUM_DRIVES independent channels. Each channel produces sector pulses, index pulses, one-cycle sector/index enables and a sector address from the shared 1 usec clock enable. Added over the single-drive generator:
- per-drive spin state machine and at-speed indication;
- configurable pulse width, index offset and counter widths;
- configuration latched per revolution;
- defined behaviour for illegal configuration.
It sits between the timing generator and the per-drive bus/interface logic.

---
 rtl/multi_drive_sector_index_gen.sv | 91 +++++++++
 tb/tb_multi_drive_sector_index_gen.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/multi_drive_sector_index_gen.sv
// multi_drive_sector_index_gen: per-drive sector/index pulse, sector address and spin-state generator
module multi_drive_sector_index_gen #(
    parameter int NUM_DRIVES = 4,
    parameter int CNT_W      = 16,
    parameter int SECT_W     = 5,
    parameter int PULSE_USEC = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clkenbl_1usec,
    input  logic [NUM_DRIVES-1:0]        drive_spinning,
    input  logic [SECT_W-1:0]            number_of_sectors,
    input  logic [CNT_W-1:0]             microseconds_per_sector,
    input  logic [CNT_W-1:0]             index_offset_usec,
    output logic [NUM_DRIVES-1:0]        clkenbl_sector,
    output logic [NUM_DRIVES-1:0]        clkenbl_index,
    output logic [NUM_DRIVES-1:0]        bus_sector_pulse,
    output logic [NUM_DRIVES-1:0]        bus_index_pulse,
    output logic [NUM_DRIVES*SECT_W-1:0] sector_address,
    output logic [NUM_DRIVES-1:0]        at_speed
);
    typedef enum logic [1:0] {STOPPED, SPINUP, RUNNING} state_t;
    localparam logic [CNT_W-1:0] MPS_MIN = CNT_W'(PULSE_USEC + 2);
    localparam logic [CNT_W-1:0] PW_C    = CNT_W'(PULSE_USEC);
    localparam logic [CNT_W:0]   PW_X    = (CNT_W+1)'(PULSE_USEC);
    genvar d;
    generate
        for (d = 0; d < NUM_DRIVES; d++) begin : g_drive
            state_t state, state_nx;
            logic [CNT_W-1:0] counter, mps_l, ioff_l;
            logic [SECT_W-1:0] sector, nsect_l;
            logic sect_end, last_sect, wrap, run, idx_ok, idx_set, idx_clr, sec_clr;
            logic ce_sec, ce_idx, sec_pulse, idx_pulse, spd;
            always_comb begin
                sect_end  = clkenbl_1usec && counter == mps_l;
                last_sect = sector == nsect_l - 1'b1;
                wrap      = sect_end && last_sect;
                run       = state == RUNNING;
                // index is only legal if the whole pulse fits inside the sector
                idx_ok    = ioff_l != '0 && ({1'b0, ioff_l} + PW_X <= {1'b0, mps_l});
                idx_set   = run && idx_ok && clkenbl_1usec && last_sect && counter == ioff_l;
                idx_clr   = clkenbl_1usec && {1'b0, counter} == {1'b0, ioff_l} + PW_X;
                sec_clr   = clkenbl_1usec && counter == PW_C;
                state_nx  = !drive_spinning[d] ? STOPPED :
                            state == STOPPED ? SPINUP :
                            (state == SPINUP && wrap) ? RUNNING : state;
            end
            always_ff @(posedge clock)
                state <= reset ? STOPPED : state_nx;
            always_ff @(posedge clock) begin
                if (reset || !drive_spinning[d]) begin
                    counter   <= CNT_W'(1);
                    sector    <= '0;
                    nsect_l   <= SECT_W'(1);
                    mps_l     <= MPS_MIN;
                    ioff_l    <= '0;
                    ce_sec    <= 1'b0;
                    ce_idx    <= 1'b0;
                    sec_pulse <= 1'b0;
                    idx_pulse <= 1'b0;
                    spd       <= 1'b0;
                end else begin
                    if (state == STOPPED || wrap) begin
                        nsect_l <= number_of_sectors == '0 ? SECT_W'(1) : number_of_sectors;
                        mps_l   <= microseconds_per_sector < MPS_MIN ? MPS_MIN : microseconds_per_sector;
                        ioff_l  <= index_offset_usec;
                    end
                    if (state == STOPPED) begin
                        counter <= CNT_W'(1);
                        sector  <= '0;
                    end else if (clkenbl_1usec) begin
                        counter <= sect_end ? CNT_W'(1) : counter + 1'b1;
                        if (sect_end)
                            sector <= last_sect ? '0 : sector + 1'b1;
                    end
                    ce_sec    <= run && sect_end;
                    ce_idx    <= idx_set;
                    sec_pulse <= (run && sect_end) || (sec_pulse && !sec_clr);
                    idx_pulse <= idx_set || (idx_pulse && !idx_clr);
                    spd       <= spd || (state == SPINUP && wrap);
                end
            end
            assign clkenbl_sector[d]                   = ce_sec;
            assign clkenbl_index[d]                    = ce_idx;
            assign bus_sector_pulse[d]                 = sec_pulse;
            assign bus_index_pulse[d]                  = idx_pulse;
            assign at_speed[d]                         = spd;
            assign sector_address[d*SECT_W +: SECT_W] = sector;
        end
    endgenerate
endmodule

// File: tb/tb_multi_drive_sector_index_gen.sv
// tb_multi_drive_sector_index_gen: compares every clock against a revolution-time model of each drive
module tb_multi_drive_sector_index_gen;
    localparam int ND = 2, CW = 16, SW = 5, P = 2;
    logic clock = 0, reset, ce;
    logic [ND-1:0] spin;
    logic [SW-1:0] nsect;
    logic [CW-1:0] mps, ioff;
    logic [ND-1:0] cs, ci, bsp, bip, ats;
    logic [ND*SW-1:0] sa;

    multi_drive_sector_index_gen #(.NUM_DRIVES(ND), .CNT_W(CW), .SECT_W(SW), .PULSE_USEC(P)) dut (
        .clock(clock), .reset(reset), .clkenbl_1usec(ce), .drive_spinning(spin),
        .number_of_sectors(nsect), .microseconds_per_sector(mps), .index_offset_usec(ioff),
        .clkenbl_sector(cs), .clkenbl_index(ci), .bus_sector_pulse(bsp), .bus_index_pulse(bip),
        .sector_address(sa), .at_speed(ats)
    );

    always #5 clock = ~clock;

    int n_assert = 0, n_fail = 0, cyc = 0, ce_div = 2;
    bit rnd_ce = 0;
    string phase = "reset";
    // model: on = spinning, run = completed a revolution, rt = usec elapsed in current revolution
    bit on[ND], run[ND], e_sec[ND], e_idx[ND];
    int rt[ND], ns[ND], mp[ND], io[ND], sp_rem[ND], ip_rem[ND];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s observed %0h expected %0h", phase, tag, obs, exp);
        end
    endtask

    function automatic void latch(int d);
        ns[d] = (nsect == 0) ? 1 : int'(nsect);
        mp[d] = (int'(mps) < P + 2) ? P + 2 : int'(mps);
        io[d] = int'(ioff);
    endfunction

    task automatic model_update();
        for (int d = 0; d < ND; d++) begin
            int pos, sec;
            e_sec[d] = 0;
            e_idx[d] = 0;
            if (reset || !spin[d]) begin
                on[d] = 0; run[d] = 0; rt[d] = 0; sp_rem[d] = 0; ip_rem[d] = 0;
                continue;
            end
            if (!on[d]) begin
                on[d] = 1; run[d] = 0; rt[d] = 0;
                latch(d);
                continue;
            end
            if (!ce) continue;
            pos = rt[d] % mp[d] + 1;
            sec = rt[d] / mp[d];
            if (sp_rem[d] > 0) sp_rem[d]--;
            if (ip_rem[d] > 0) ip_rem[d]--;
            if (run[d] && pos == mp[d]) begin
                e_sec[d] = 1; sp_rem[d] = P;
            end
            if (run[d] && sec == ns[d] - 1 && io[d] != 0 && io[d] + P <= mp[d] && pos == io[d]) begin
                e_idx[d] = 1; ip_rem[d] = P;
            end
            rt[d]++;
            if (rt[d] == ns[d] * mp[d]) begin
                rt[d] = 0; run[d] = 1;
                latch(d);
            end
        end
    endtask

    task automatic check();
        logic [ND-1:0] x_cs, x_ci, x_bsp, x_bip, x_at;
        logic [ND*SW-1:0] x_sa;
        for (int d = 0; d < ND; d++) begin
            x_cs[d]  = e_sec[d];
            x_ci[d]  = e_idx[d];
            x_bsp[d] = sp_rem[d] > 0;
            x_bip[d] = ip_rem[d] > 0;
            x_at[d]  = run[d];
            x_sa[d*SW +: SW] = on[d] ? SW'(rt[d] / mp[d]) : '0;
        end
        chk("clkenbl_sector", 32'(cs), 32'(x_cs));
        chk("clkenbl_index", 32'(ci), 32'(x_ci));
        chk("bus_sector_pulse", 32'(bsp), 32'(x_bsp));
        chk("bus_index_pulse", 32'(bip), 32'(x_bip));
        chk("at_speed", 32'(ats), 32'(x_at));
        chk("sector_address", 32'(sa), 32'(x_sa));
    endtask

    task automatic step();
        ce = rnd_ce ? 1'($urandom_range(0, 1)) : (cyc % ce_div == 0);
        @(posedge clock);
        model_update();
        #1;
        check();
        cyc++;
    endtask

    task automatic run_steps(int n);
        repeat (n) step();
    endtask

    initial begin
        reset = 1; spin = '0; ce = 0; nsect = 12; mps = 33; ioff = 6;
        run_steps(3);
        reset = 0;
        phase = "spinup";
        spin = 2'b01;
        run_steps(100);
        phase = "two_drives";
        spin = 2'b11;
        run_steps(1600);
        phase = "mps_change";
        for (int k = 0; k < 5000 && !(on[0] && rt[0] / mp[0] == 5); k++) step();
        chk("reach_sector5", 32'(on[0] && rt[0] / mp[0] == 5), 32'd1);
        mps = 20;
        run_steps(1400);
        phase = "drop_index";
        for (int k = 0; k < 5000 && ip_rem[0] == 0; k++) step();
        chk("reach_index", 32'(ip_rem[0] > 0), 32'd1);
        spin[0] = 0;
        step();
        spin[0] = 1;
        run_steps(600);
        phase = "illegal_cfg";
        nsect = 0; mps = 2; ioff = 0;
        run_steps(2000);
        phase = "reset_mid";
        nsect = 5; mps = 9; ioff = 4;
        run_steps(300);
        reset = 1;
        step();
        reset = 0;
        run_steps(300);
        phase = "random";
        rnd_ce = 1;
        repeat (300) begin
            nsect = SW'($urandom_range(0, 6));
            mps   = CW'($urandom_range(0, 12));
            ioff  = CW'($urandom_range(0, 12));
            if ($urandom_range(0, 7) == 0) spin = ND'($urandom);
            reset = ($urandom_range(0, 40) == 0);
            step();
            reset = 0;
            run_steps($urandom_range(1, 80));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
